// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU instruction fetch and data load/store share one
// downstream port. Data wins ties, bounded by a burst limit while a fetch waits.
module mem_arbiter #(
   parameter int MAX_DATA_BURST = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    inst_read,
   input  logic [31:0]                             inst_addr,
   output logic                                    inst_resp,
   output logic [31:0]                             inst_rdata,
   input  logic                                    data_read,
   input  logic                                    data_write,
   input  logic [31:0]                             data_addr,
   input  logic [3:0]                              data_mbe,
   input  logic [31:0]                             data_wdata,
   output logic                                    data_resp,
   output logic [31:0]                             data_rdata,
   output logic                                    mem_read,
   output logic                                    mem_write,
   output logic [31:0]                             mem_addr,
   output logic [3:0]                              mem_mbe,
   output logic [31:0]                             mem_wdata,
   input  logic [31:0]                             mem_rdata,
   input  logic                                    mem_resp,
   output logic [1:0]                              dbg_state,
   output logic [$clog2(MAX_DATA_BURST+1)-1:0]     dbg_burst_cnt
);

   localparam int CW = $clog2(MAX_DATA_BURST + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DATA_BURST);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;
   logic          mem_read_q, mem_read_d;
   logic          mem_write_q, mem_write_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [3:0]    mem_mbe_q, mem_mbe_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          inst_resp_q, inst_resp_d;
   logic          data_resp_q, data_resp_d;
   logic [31:0]   inst_rdata_q, inst_rdata_d;
   logic [31:0]   data_rdata_q, data_rdata_d;
   logic          data_req;
   logic          data_grant;

   assign data_req   = data_read | data_write;
   // A waiting fetch only yields to data while the burst budget lasts.
   assign data_grant = data_req & (~inst_read | (burst_cnt_q < MAX_CNT));

   always_comb begin
      state_d      = state_q;
      burst_cnt_d  = burst_cnt_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_mbe_d    = mem_mbe_q;
      mem_wdata_d  = mem_wdata_q;
      inst_resp_d  = 1'b0;
      data_resp_d  = 1'b0;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      case (state_q)
         IDLE: begin
            if (data_grant) begin
               state_d     = SERVE_D;
               mem_write_d = data_write;
               mem_read_d  = ~data_write;
               mem_addr_d  = data_addr;
               mem_mbe_d   = data_write ? data_mbe : 4'hF;
               mem_wdata_d = data_wdata;
               if (!inst_read)
                  burst_cnt_d = '0;
               else if (burst_cnt_q != MAX_CNT)
                  burst_cnt_d = burst_cnt_q + CW'(1);
            end else if (inst_read) begin
               state_d     = SERVE_I;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               mem_addr_d  = inst_addr;
               mem_mbe_d   = 4'hF;
               mem_wdata_d = 32'h0;
               burst_cnt_d = '0;
            end
         end
         SERVE_I: begin
            if (mem_resp) begin
               state_d      = DONE;
               mem_read_d   = 1'b0;
               inst_rdata_d = mem_rdata;
               inst_resp_d  = 1'b1;
            end
         end
         SERVE_D: begin
            if (mem_resp) begin
               state_d     = DONE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               data_resp_d = 1'b1;
               if (mem_read_q)
                  data_rdata_d = mem_rdata;
            end
         end
         // The CPU still holds the finished request here, so it is not re-arbitrated.
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         burst_cnt_q  <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_mbe_q    <= 4'h0;
         mem_wdata_q  <= 32'h0;
         inst_resp_q  <= 1'b0;
         data_resp_q  <= 1'b0;
         inst_rdata_q <= 32'h0;
         data_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         burst_cnt_q  <= burst_cnt_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_mbe_q    <= mem_mbe_d;
         mem_wdata_q  <= mem_wdata_d;
         inst_resp_q  <= inst_resp_d;
         data_resp_q  <= data_resp_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   assign inst_resp     = inst_resp_q;
   assign inst_rdata    = inst_rdata_q;
   assign data_resp     = data_resp_q;
   assign data_rdata    = data_rdata_q;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_addr      = mem_addr_q;
   assign mem_mbe       = mem_mbe_q;
   assign mem_wdata     = mem_wdata_q;
   assign dbg_state     = state_q;
   assign dbg_burst_cnt = burst_cnt_q;

endmodule
